// File: rtl/conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_ctrl
// Description : Job sequencer for a convolution datapath. It runs one
//               weight-load phase per job, then an ifm-load/compute phase
//               pair for each tile, and finishes with a one-cycle DONE
//               state. It also handles abort and rejects bad configurations.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CW : width of the phase-length configuration and the phase counter
//   TW : width of the tile count and the tile index
// Ports
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   start          in   job request, sampled only in IDLE
//   abort          in   cancels the job in progress
//   cfg_wht_words  in   weight words per job (0 skips the weight load)
//   cfg_ifm_words  in   ifm words per tile
//   cfg_cmp_cycles in   compute cycles per tile
//   cfg_tiles      in   tiles per job
//   core_state     out  bit0 = ifm read enable, bit1 = wht read enable
//   core_clr       out  one-cycle pulse that clears datapath read pointers
//   busy           out  high in every state except IDLE
//   done           out  one-cycle pulse when a job completes
//   aborted        out  one-cycle pulse when a job is cancelled
//   err            out  one-cycle pulse when a start request is rejected
//   tile_idx       out  0-based index of the current tile
// ============================================================================
module conv_ctrl #(
    parameter int CW = 16,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] cfg_wht_words,
    input  logic [CW-1:0] cfg_ifm_words,
    input  logic [CW-1:0] cfg_cmp_cycles,
    input  logic [TW-1:0] cfg_tiles,
    output logic [1:0]    core_state,
    output logic          core_clr,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic          err,
    output logic [TW-1:0] tile_idx
);

    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
    localparam logic [TW-1:0] C_TILE_ONE = TW'(1);

    localparam logic [1:0] C_CS_IDLE = 2'b00;
    localparam logic [1:0] C_CS_IFM  = 2'b01;
    localparam logic [1:0] C_CS_WHT  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_WHT = 3'd1,
        S_LOAD_IFM = 3'd2,
        S_COMPUTE  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] phase_cnt;
    logic [CW-1:0] ifm_words;
    logic [CW-1:0] cmp_cycles;
    logic [TW-1:0] tiles;

    // The weight count is needed only once per job, at the moment the
    // LOAD_WHT phase is entered. The phase counter loads it on the accepting
    // edge, which captures it without a separate register.
    logic cfg_ok;
    assign cfg_ok = (cfg_tiles != '0) && (cfg_ifm_words != '0) && (cfg_cmp_cycles != '0);

    // The phase counter is loaded with (length - 1) on phase entry. A phase
    // ends in the cycle where the counter reads zero, so each phase lasts
    // exactly its configured number of cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            phase_cnt  <= '0;
            ifm_words  <= '0;
            cmp_cycles <= '0;
            tiles      <= '0;
            core_state <= C_CS_IDLE;
            core_clr   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            err        <= 1'b0;
            tile_idx   <= '0;
        end else begin
            core_clr <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            err      <= 1'b0;

            if (state == S_IDLE) begin
                // abort is ignored here, and tile_idx keeps its last value
                if (start) begin
                    if (cfg_ok) begin
                        ifm_words  <= cfg_ifm_words;
                        cmp_cycles <= cfg_cmp_cycles;
                        tiles      <= cfg_tiles;
                        tile_idx   <= '0;
                        core_clr   <= 1'b1;
                        busy       <= 1'b1;
                        if (cfg_wht_words != '0) begin
                            state      <= S_LOAD_WHT;
                            phase_cnt  <= cfg_wht_words - C_CNT_ONE;
                            core_state <= C_CS_WHT;
                        end else begin
                            state      <= S_LOAD_IFM;
                            phase_cnt  <= cfg_ifm_words - C_CNT_ONE;
                            core_state <= C_CS_IFM;
                        end
                    end else begin
                        err <= 1'b1;
                    end
                end
            end else if (abort) begin
                // abort takes priority over any phase transition, including
                // the final COMPUTE cycle, so done is never raised with it
                state      <= S_IDLE;
                phase_cnt  <= '0;
                core_state <= C_CS_IDLE;
                busy       <= 1'b0;
                aborted    <= 1'b1;
            end else begin
                case (state)
                    S_LOAD_WHT: begin
                        if (phase_cnt == '0) begin
                            state      <= S_LOAD_IFM;
                            phase_cnt  <= ifm_words - C_CNT_ONE;
                            core_state <= C_CS_IFM;
                        end else begin
                            phase_cnt <= phase_cnt - C_CNT_ONE;
                        end
                    end
                    S_LOAD_IFM: begin
                        if (phase_cnt == '0) begin
                            state      <= S_COMPUTE;
                            phase_cnt  <= cmp_cycles - C_CNT_ONE;
                            core_state <= C_CS_IDLE;
                        end else begin
                            phase_cnt <= phase_cnt - C_CNT_ONE;
                        end
                    end
                    S_COMPUTE: begin
                        if (phase_cnt == '0) begin
                            if (tile_idx == tiles - C_TILE_ONE) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state      <= S_LOAD_IFM;
                                tile_idx   <= tile_idx + C_TILE_ONE;
                                phase_cnt  <= ifm_words - C_CNT_ONE;
                                core_state <= C_CS_IFM;
                            end
                        end else begin
                            phase_cnt <= phase_cnt - C_CNT_ONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state      <= S_IDLE;
                        phase_cnt  <= '0;
                        core_state <= C_CS_IDLE;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
